// File: rtl/ecc_scrub_pkg.sv
// Shared types and helpers for the ECC scrub controller and its checker.
// Code layout: data bit i sits at the i-th non-power-of-two position of a
// 63-position Hamming word; parity[5:0] are the Hamming check bits and
// parity[6] is overall parity over all data and parity[5:0].
package ecc_scrub_pkg;

   localparam int ECC_DATA_W   = 51;
   localparam int ECC_PARITY_W = 7;
   localparam int ECC_SYN_W    = 6;
   localparam int ECC_MAX_POS  = 57;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RD,
      ST_CHK,
      ST_WB
   } scrub_state_t;

   // Hamming position (1..57) of data bit idx
   function automatic logic [ECC_SYN_W-1:0] ecc_data_pos(input int idx);
      logic [ECC_SYN_W-1:0] pos;
      int                   cnt;
      pos = '0;
      cnt = 0;
      for (int p = 1; p < 64; p++) begin
         if ((p & (p - 1)) != 0) begin
            if (cnt == idx) pos = ECC_SYN_W'(p);
            cnt++;
         end
      end
      return pos;
   endfunction

   // Hamming check bits over the data word
   function automatic logic [ECC_SYN_W-1:0] ecc_check_bits(input logic [ECC_DATA_W-1:0] data);
      logic [ECC_SYN_W-1:0] chk;
      logic [ECC_SYN_W-1:0] pos;
      chk = '0;
      for (int i = 0; i < ECC_DATA_W; i++) begin
         pos = ecc_data_pos(i);
         for (int k = 0; k < ECC_SYN_W; k++) begin
            if (pos[k]) chk[k] = chk[k] ^ data[i];
         end
      end
      return chk;
   endfunction

   // Saturating increment for a counter of the given width
   function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
      logic [31:0] max_val;
      max_val = (32'h1 << width) - 32'h1;
      return (val >= max_val) ? max_val : val + 32'h1;
   endfunction

endpackage

// File: rtl/ecc_51_fault_detc.sv
// Dual-redundant SEC-DED checker for 51 data / 7 parity bits. Two syndrome
// copies are compared; a disagreement is reported as a checker fault.
module ecc_51_fault_detc
   import ecc_scrub_pkg::*;
(
   input  logic [ECC_DATA_W-1:0]   data,
   input  logic [ECC_PARITY_W-1:0] parity,
   input  logic                    ecc_fault_detc_en,
   input  logic                    bypass,
   output logic [ECC_DATA_W-1:0]   data_out,
   output logic                    sbit_err,
   output logic                    dbit_err,
   output logic                    ecc_fault
);

   logic [ECC_SYN_W-1:0] syn_a;
   logic [ECC_SYN_W-1:0] syn_b;
   logic                 ovr_a;
   logic                 ovr_b;

   assign syn_a = ecc_check_bits(data) ^ parity[ECC_SYN_W-1:0];
   assign syn_b = ecc_check_bits(data) ^ parity[ECC_SYN_W-1:0];
   assign ovr_a = ^{data, parity};
   assign ovr_b = ^{parity, data};

   assign ecc_fault = ecc_fault_detc_en & ~bypass & ((syn_a != syn_b) | (ovr_a != ovr_b));

   // Classify the word from copy A and flip the erroneous data bit
   always_comb begin
      data_out = data;
      sbit_err = 1'b0;
      dbit_err = 1'b0;
      if (!bypass) begin
         if (ovr_a) begin
            if ((syn_a & (syn_a - 1'b1)) == '0) begin
               sbit_err = 1'b1;
            end else if (syn_a <= ECC_SYN_W'(ECC_MAX_POS)) begin
               sbit_err = 1'b1;
               for (int i = 0; i < ECC_DATA_W; i++) begin
                  if (ecc_data_pos(i) == syn_a) data_out[i] = ~data[i];
               end
            end else begin
               dbit_err = 1'b1;
            end
         end else if (syn_a != '0) begin
            dbit_err = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ecc_51_scrub_ctrl.sv
// Background scrubber: walks the RAM in idle cycles, checks each word,
// writes back corrected single-bit errors and keeps event counters.
module ecc_51_scrub_ctrl
   import ecc_scrub_pkg::*;
#(
   parameter int DATA_WIDTH   = ECC_DATA_W,
   parameter int PARITY_WIDTH = ECC_PARITY_W,
   parameter int ADDR_WIDTH   = 6,
   parameter int DEPTH        = 64,
   parameter int CNT_WIDTH    = 8
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    scrub_en,
   input  logic                    ecc_fault_detc_en,
   input  logic [15:0]             scrub_interval,
   input  logic                    cnt_clr,
   input  logic                    func_rd_req,
   input  logic                    func_wr_req,
   input  logic [ADDR_WIDTH-1:0]   func_wr_addr,
   input  logic [DATA_WIDTH-1:0]   ram_rd_data,
   input  logic [PARITY_WIDTH-1:0] ram_rd_parity,
   output logic                    scrub_rd_en,
   output logic                    scrub_wr_en,
   output logic [ADDR_WIDTH-1:0]   scrub_addr,
   output logic [DATA_WIDTH-1:0]   scrub_wr_data,
   output logic                    scrub_busy,
   output logic                    pass_done,
   output logic [CNT_WIDTH-1:0]    sbit_cnt,
   output logic [CNT_WIDTH-1:0]    dbit_cnt,
   output logic [CNT_WIDTH-1:0]    fault_cnt,
   output logic                    err_dbit,
   output logic                    err_fault,
   output logic [ADDR_WIDTH-1:0]   dbit_addr
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   scrub_state_t           state;
   scrub_state_t           state_n;
   logic [15:0]            int_cnt;
   logic [15:0]            int_cnt_n;
   logic [ADDR_WIDTH-1:0]  addr_n;
   logic [DATA_WIDTH-1:0]  wr_data_n;
   logic [CNT_WIDTH-1:0]   sbit_n;
   logic [CNT_WIDTH-1:0]   dbit_n;
   logic [CNT_WIDTH-1:0]   fault_n;
   logic                   err_dbit_n;
   logic                   err_fault_n;
   logic [ADDR_WIDTH-1:0]  dbit_addr_n;
   logic                   stale;
   logic                   stale_n;
   logic                   rd_strobe;
   logic                   wr_strobe;
   logic                   word_done;
   logic                   func_busy;
   logic                   wr_hit;

   logic [DATA_WIDTH-1:0]  chk_data;
   logic                   chk_sbit;
   logic                   chk_dbit;
   logic                   chk_fault;

   ecc_51_fault_detc u_chk (
      .data              (ram_rd_data),
      .parity            (ram_rd_parity),
      .ecc_fault_detc_en (ecc_fault_detc_en),
      .bypass            (1'b0),
      .data_out          (chk_data),
      .sbit_err          (chk_sbit),
      .dbit_err          (chk_dbit),
      .ecc_fault         (chk_fault)
   );

   assign func_busy = func_rd_req | func_wr_req;
   assign wr_hit    = func_wr_req & (func_wr_addr == scrub_addr);

   // Strobes are blocked during reset so a pending write-back is dropped
   assign scrub_rd_en = rd_strobe & ~rst;
   assign scrub_wr_en = wr_strobe & ~rst;
   assign pass_done   = word_done & (scrub_addr == LAST_ADDR) & ~rst;
   assign scrub_busy  = (state != ST_IDLE);

   // Next-state, strobe and bookkeeping decode
   always_comb begin
      state_n     = state;
      int_cnt_n   = int_cnt;
      addr_n      = scrub_addr;
      wr_data_n   = scrub_wr_data;
      sbit_n      = sbit_cnt;
      dbit_n      = dbit_cnt;
      fault_n     = fault_cnt;
      err_dbit_n  = err_dbit;
      err_fault_n = err_fault;
      dbit_addr_n = dbit_addr;
      stale_n     = stale;
      rd_strobe   = 1'b0;
      wr_strobe   = 1'b0;
      word_done   = 1'b0;

      case (state)
         ST_IDLE: begin
            if (scrub_en) begin
               state_n   = ST_WAIT;
               int_cnt_n = scrub_interval;
            end
         end
         ST_WAIT: begin
            if (!scrub_en) begin
               state_n = ST_IDLE;
            end else if (int_cnt == '0) begin
               state_n = ST_RD;
            end else begin
               int_cnt_n = int_cnt - 16'd1;
            end
         end
         ST_RD: begin
            if (!func_busy) begin
               rd_strobe = 1'b1;
               stale_n   = 1'b0;
               state_n   = ST_CHK;
            end
         end
         ST_CHK: begin
            if (chk_fault) begin
               fault_n     = CNT_WIDTH'(sat_inc(32'(fault_cnt), CNT_WIDTH));
               err_fault_n = 1'b1;
               word_done   = 1'b1;
            end else if (chk_dbit) begin
               dbit_n     = CNT_WIDTH'(sat_inc(32'(dbit_cnt), CNT_WIDTH));
               err_dbit_n = 1'b1;
               if (!err_dbit) dbit_addr_n = scrub_addr;
               word_done  = 1'b1;
            end else if (chk_sbit) begin
               sbit_n    = CNT_WIDTH'(sat_inc(32'(sbit_cnt), CNT_WIDTH));
               wr_data_n = chk_data;
               stale_n   = wr_hit;
               state_n   = ST_WB;
            end else begin
               word_done = 1'b1;
            end
         end
         ST_WB: begin
            if (stale || wr_hit) begin
               word_done = 1'b1;
            end else if (!func_busy) begin
               wr_strobe = 1'b1;
               word_done = 1'b1;
            end
         end
         default: state_n = ST_IDLE;
      endcase

      if (word_done) begin
         addr_n = (scrub_addr == LAST_ADDR) ? '0 : scrub_addr + 1'b1;
         if (scrub_en) begin
            state_n   = ST_WAIT;
            int_cnt_n = scrub_interval;
         end else begin
            state_n = ST_IDLE;
         end
      end

      if (cnt_clr) begin
         sbit_n      = '0;
         dbit_n      = '0;
         fault_n     = '0;
         err_dbit_n  = 1'b0;
         err_fault_n = 1'b0;
         dbit_addr_n = '0;
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         int_cnt       <= '0;
         scrub_addr    <= '0;
         scrub_wr_data <= '0;
         sbit_cnt      <= '0;
         dbit_cnt      <= '0;
         fault_cnt     <= '0;
         err_dbit      <= 1'b0;
         err_fault     <= 1'b0;
         dbit_addr     <= '0;
         stale         <= 1'b0;
      end else begin
         state         <= state_n;
         int_cnt       <= int_cnt_n;
         scrub_addr    <= addr_n;
         scrub_wr_data <= wr_data_n;
         sbit_cnt      <= sbit_n;
         dbit_cnt      <= dbit_n;
         fault_cnt     <= fault_n;
         err_dbit      <= err_dbit_n;
         err_fault     <= err_fault_n;
         dbit_addr     <= dbit_addr_n;
         stale         <= stale_n;
      end
   end

endmodule

// File: tb/tb_ecc_51_scrub_ctrl.sv
// Directed testbench for ecc_51_scrub_ctrl with a behavioural RAM model.
module tb_ecc_51_scrub_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        scrub_en;
   logic        ecc_fault_detc_en;
   logic [15:0] scrub_interval;
   logic        cnt_clr;
   logic        func_rd_req;
   logic        func_wr_req;
   logic [5:0]  func_wr_addr;
   logic [50:0] ram_rd_data = '0;
   logic [6:0]  ram_rd_parity = '0;
   logic        scrub_rd_en;
   logic        scrub_wr_en;
   logic [5:0]  scrub_addr;
   logic [50:0] scrub_wr_data;
   logic        scrub_busy;
   logic        pass_done;
   logic [7:0]  sbit_cnt;
   logic [7:0]  dbit_cnt;
   logic [7:0]  fault_cnt;
   logic        err_dbit;
   logic        err_fault;
   logic [5:0]  dbit_addr;

   logic        mem_init;
   logic        corrupt_req;
   logic [5:0]  corrupt_addr;
   logic [50:0] corrupt_mask;
   logic        inject_all;
   logic [50:0] mem_data [64];
   logic [6:0]  mem_par  [64];
   int          rd_count = 0;
   int          wr_count = 0;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc;
   int          n_wr;
   int          base_wr;
   bit          found;

   ecc_51_scrub_ctrl dut (
      .clk               (clk),
      .rst               (rst),
      .scrub_en          (scrub_en),
      .ecc_fault_detc_en (ecc_fault_detc_en),
      .scrub_interval    (scrub_interval),
      .cnt_clr           (cnt_clr),
      .func_rd_req       (func_rd_req),
      .func_wr_req       (func_wr_req),
      .func_wr_addr      (func_wr_addr),
      .ram_rd_data       (ram_rd_data),
      .ram_rd_parity     (ram_rd_parity),
      .scrub_rd_en       (scrub_rd_en),
      .scrub_wr_en       (scrub_wr_en),
      .scrub_addr        (scrub_addr),
      .scrub_wr_data     (scrub_wr_data),
      .scrub_busy        (scrub_busy),
      .pass_done         (pass_done),
      .sbit_cnt          (sbit_cnt),
      .dbit_cnt          (dbit_cnt),
      .fault_cnt         (fault_cnt),
      .err_dbit          (err_dbit),
      .err_fault         (err_fault),
      .dbit_addr         (dbit_addr)
   );

   always #5 clk = ~clk;

   // Reference encoder: walk Hamming positions, placing data on non-powers of two
   function automatic logic [6:0] tb_encode(input logic [50:0] d);
      logic [6:0] p;
      int         idx;
      p   = '0;
      idx = 0;
      for (int pos = 1; pos < 64; pos++) begin
         if (((pos & (pos - 1)) != 0) && (idx < 51)) begin
            for (int k = 0; k < 6; k++) begin
               if (((pos >> k) & 1) == 1) p[k] = p[k] ^ d[idx];
            end
            idx++;
         end
      end
      p[6] = (^d) ^ (^p[5:0]);
      return p;
   endfunction

   function automatic logic [50:0] orig_word(input int i);
      logic [63:0] t;
      t = 64'h0123_4567_89AB_CDEF * 64'(i + 1);
      return t[50:0];
   endfunction

   // RAM model: one-cycle read latency, scrub and functional writes, fault injection
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) begin
            mem_data[i] <= orig_word(i);
            mem_par[i]  <= tb_encode(orig_word(i));
         end
      end else begin
         if (corrupt_req) mem_data[corrupt_addr] <= mem_data[corrupt_addr] ^ corrupt_mask;
         if (scrub_wr_en) begin
            mem_data[scrub_addr] <= scrub_wr_data;
            mem_par[scrub_addr]  <= tb_encode(scrub_wr_data);
         end
         if (func_wr_req) begin
            mem_data[func_wr_addr] <= orig_word(int'(func_wr_addr));
            mem_par[func_wr_addr]  <= tb_encode(orig_word(int'(func_wr_addr)));
         end
      end
      if (scrub_rd_en) begin
         ram_rd_data   <= mem_data[scrub_addr] ^ (inject_all ? 51'd1 : 51'd0);
         ram_rd_parity <= mem_par[scrub_addr];
         rd_count      <= rd_count + 1;
      end
      if (scrub_wr_en) wr_count <= wr_count + 1;
   end

   task automatic next_cycle();
      @(negedge clk);
   endtask

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check_output({tag, "_busy"}, 64'(scrub_busy), 64'd0);
      check_output({tag, "_rd_en"}, 64'(scrub_rd_en), 64'd0);
      check_output({tag, "_wr_en"}, 64'(scrub_wr_en), 64'd0);
      check_output({tag, "_pass_done"}, 64'(pass_done), 64'd0);
      check_output({tag, "_addr"}, 64'(scrub_addr), 64'd0);
      check_output({tag, "_wr_data"}, 64'(scrub_wr_data), 64'd0);
      check_output({tag, "_counters"}, {40'd0, sbit_cnt, dbit_cnt, fault_cnt}, 64'd0);
      check_output({tag, "_flags"}, {62'd0, err_dbit, err_fault}, 64'd0);
      check_output({tag, "_dbit_addr"}, 64'(dbit_addr), 64'd0);
   endtask

   // Advance until pass_done is seen in the current cycle or the bound expires
   task automatic wait_pass(input int bound, output int cycles, output bit seen);
      cycles = 0;
      seen   = 1'b0;
      while (!seen && cycles < bound) begin
         if (pass_done) seen = 1'b1;
         else begin
            next_cycle();
            cycles++;
            #1;
         end
      end
   endtask

   // Advance until a scrub read is issued (optionally at a given address)
   task automatic wait_rd(input bit any_addr, input logic [5:0] a, input int bound, output bit seen);
      int cycles;
      cycles = 0;
      seen   = 1'b0;
      while (!seen && cycles < bound) begin
         if (scrub_rd_en && (any_addr || scrub_addr == a)) seen = 1'b1;
         else begin
            next_cycle();
            cycles++;
            #1;
         end
      end
   endtask

   task automatic apply_corruption(input logic [5:0] a, input logic [50:0] mask);
      corrupt_addr = a;
      corrupt_mask = mask;
      corrupt_req  = 1'b1;
      next_cycle();
      corrupt_req  = 1'b0;
   endtask

   // Directed test sequence
   initial begin
      rst = 1'b1; scrub_en = 1'b0; ecc_fault_detc_en = 1'b1; scrub_interval = 16'd0;
      cnt_clr = 1'b0; func_rd_req = 1'b0; func_wr_req = 1'b0; func_wr_addr = '0;
      mem_init = 1'b1; corrupt_req = 1'b0; corrupt_addr = '0; corrupt_mask = '0;
      inject_all = 1'b0;
      next_cycle();
      next_cycle();
      mem_init = 1'b0;
      #1;
      check_reset_values("reset");

      // Clean pass with interval 0
      next_cycle();
      rst = 1'b0;
      scrub_en = 1'b1;
      #1;
      wait_pass(400, cyc, found);
      check_output("clean_pass_seen", 64'(found), 64'd1);
      check_output("clean_pass_cycles", 64'(cyc), 64'd192);
      check_output("clean_reads", 64'(rd_count), 64'd64);
      check_output("clean_writes", 64'(wr_count), 64'd0);
      check_output("clean_counters", {40'd0, sbit_cnt, dbit_cnt, fault_cnt}, 64'd0);
      scrub_en = 1'b0;
      next_cycle();
      #1;
      check_output("clean_pass_one_shot", 64'(pass_done), 64'd0);
      check_output("clean_idle", 64'(scrub_busy), 64'd0);
      check_output("clean_addr_wrap", 64'(scrub_addr), 64'd0);

      // Single-bit error at address 5 bit 17 is written back corrected
      apply_corruption(6'd5, 51'd1 << 17);
      scrub_en = 1'b1;
      #1;
      cyc = 0;
      found = 1'b0;
      while (!found && cyc < 100) begin
         if (scrub_wr_en) found = 1'b1;
         else begin
            next_cycle();
            cyc++;
            #1;
         end
      end
      check_output("sbit_wb_seen", 64'(found), 64'd1);
      check_output("sbit_wb_cycle", 64'(cyc), 64'd19);
      check_output("sbit_wb_addr", 64'(scrub_addr), 64'd5);
      check_output("sbit_wb_data", 64'(scrub_wr_data), 64'(orig_word(5)));
      check_output("sbit_cnt_one", 64'(sbit_cnt), 64'd1);
      wait_pass(300, cyc, found);
      check_output("sbit_pass1_seen", 64'(found), 64'd1);
      next_cycle();
      #1;
      wait_pass(300, cyc, found);
      check_output("sbit_pass2_seen", 64'(found), 64'd1);
      scrub_en = 1'b0;
      check_output("sbit_reread_clean", 64'(sbit_cnt), 64'd1);
      check_output("sbit_single_write", 64'(wr_count), 64'd1);
      check_output("sbit_reads", 64'(rd_count), 64'd192);
      next_cycle();

      // Double-bit errors at addresses 9 and 20
      cnt_clr = 1'b1;
      next_cycle();
      cnt_clr = 1'b0;
      #1;
      check_output("clr_sbit", 64'(sbit_cnt), 64'd0);
      apply_corruption(6'd9, (51'd1 << 3) | (51'd1 << 4));
      apply_corruption(6'd20, 51'd1 | (51'd1 << 50));
      scrub_en = 1'b1;
      #1;
      wait_pass(300, cyc, found);
      check_output("dbit_pass_seen", 64'(found), 64'd1);
      scrub_en = 1'b0;
      check_output("dbit_cnt", 64'(dbit_cnt), 64'd2);
      check_output("dbit_flag", 64'(err_dbit), 64'd1);
      check_output("dbit_addr_first", 64'(dbit_addr), 64'd9);
      check_output("dbit_no_writes", 64'(wr_count), 64'd1);
      check_output("dbit_others", {48'd0, sbit_cnt, fault_cnt}, 64'd0);
      next_cycle();
      mem_init = 1'b1;
      next_cycle();
      mem_init = 1'b0;

      // Functional read contention in RD, then functional write aborting write-back
      cnt_clr = 1'b1;
      corrupt_addr = 6'd5;
      corrupt_mask = 51'd1 << 17;
      corrupt_req = 1'b1;
      next_cycle();
      cnt_clr = 1'b0;
      corrupt_req = 1'b0;
      scrub_en = 1'b1;
      next_cycle();
      next_cycle();
      func_rd_req = 1'b1;
      #1;
      check_output("rd_hold_busy", 64'(scrub_busy), 64'd1);
      for (int i = 0; i < 10; i++) begin
         if (i > 0) begin
            next_cycle();
            #1;
         end
         check_output($sformatf("rd_hold_%0d", i), 64'(scrub_rd_en), 64'd0);
      end
      next_cycle();
      func_rd_req = 1'b0;
      #1;
      check_output("rd_release_issue", 64'(scrub_rd_en), 64'd1);
      check_output("rd_release_addr", 64'(scrub_addr), 64'd0);
      wait_rd(1'b0, 6'd5, 100, found);
      check_output("abort_rd5_seen", 64'(found), 64'd1);
      next_cycle();
      func_wr_req = 1'b1;
      func_wr_addr = 6'd5;
      #1;
      check_output("abort_chk_no_wr", 64'(scrub_wr_en), 64'd0);
      next_cycle();
      func_wr_req = 1'b0;
      #1;
      check_output("abort_wb_no_wr", 64'(scrub_wr_en), 64'd0);
      check_output("abort_sbit_counted", 64'(sbit_cnt), 64'd1);
      wait_pass(300, cyc, found);
      check_output("abort_pass_seen", 64'(found), 64'd1);
      scrub_en = 1'b0;
      check_output("abort_no_writes", 64'(wr_count), 64'd1);
      next_cycle();

      // Checker mismatch, then clear
      cnt_clr = 1'b1;
      next_cycle();
      cnt_clr = 1'b0;
      force dut.u_chk.syn_b = 6'h2A;
      scrub_en = 1'b1;
      #1;
      wait_rd(1'b1, 6'd0, 20, found);
      check_output("fault_rd_seen", 64'(found), 64'd1);
      next_cycle();
      scrub_en = 1'b0;
      next_cycle();
      release dut.u_chk.syn_b;
      #1;
      check_output("fault_cnt", 64'(fault_cnt), 64'd1);
      check_output("fault_flag", 64'(err_fault), 64'd1);
      check_output("fault_priority", {48'd0, sbit_cnt, dbit_cnt}, 64'd0);
      check_output("fault_idle", 64'(scrub_busy), 64'd0);
      cnt_clr = 1'b1;
      next_cycle();
      cnt_clr = 1'b0;
      #1;
      check_output("fault_clr", {55'd0, fault_cnt, err_fault}, 64'd0);

      // Saturation of sbit_cnt over 300 corrected words
      inject_all = 1'b1;
      scrub_en = 1'b1;
      #1;
      n_wr = 0;
      cyc = 0;
      while (n_wr < 300 && cyc < 2000) begin
         if (scrub_wr_en) n_wr++;
         if (n_wr < 300) begin
            next_cycle();
            cyc++;
            #1;
         end
      end
      scrub_en = 1'b0;
      check_output("sat_writes", 64'(n_wr), 64'd300);
      next_cycle();
      next_cycle();
      #1;
      check_output("sat_sbit_cnt", 64'(sbit_cnt), 64'd255);

      // Reset asserted during write-back
      scrub_en = 1'b1;
      #1;
      wait_rd(1'b1, 6'd0, 20, found);
      check_output("rstwb_rd_seen", 64'(found), 64'd1);
      next_cycle();
      next_cycle();
      rst = 1'b1;
      base_wr = wr_count;
      #1;
      check_output("rstwb_no_strobe", 64'(scrub_wr_en), 64'd0);
      next_cycle();
      rst = 1'b0;
      scrub_en = 1'b0;
      inject_all = 1'b0;
      #1;
      check_output("rstwb_no_write", 64'(wr_count), 64'(base_wr));
      check_reset_values("rstwb");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
